// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// Purpose: generates the raster timing for a VGA-style display. It keeps a
// horizontal pixel counter, a vertical line counter and a frame counter. The
// counters move forward only on cycles where the pixel strobe is high. Every
// output is decoded combinationally from the counters. Timing is set by
// parameters; the defaults give 640x480 at 60 Hz.
// Line order:  front porch, sync, back porch, active pixels.
// Frame order: active lines, front porch, sync, back porch.
// Ports:
//   i_clk        sole clock, rising edge
//   i_rst        synchronous active-high reset (overrides i_pix_stb)
//   i_pix_stb    pixel strobe; counters advance only when high
//   o_hs, o_vs   sync outputs at H_POL / V_POL asserted level
//   o_blanking   high outside the active region
//   o_active     high inside the active region (~o_blanking)
//   o_screenend  strobe-qualified pulse on the last pixel of the frame
//   o_animate    strobe-qualified pulse on the last pixel of the last active line
//   o_line_end   strobe-qualified pulse on the last pixel of every line
//   o_x, o_y     active-area coordinates (x=0 / y clamped when blanking)
//   o_frame      frame count, wraps modulo 2^FRAME_W
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0,
  parameter int X_W      = 10,
  parameter int Y_W      = 9,
  parameter int CNT_W    = 11,
  parameter int FRAME_W  = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_pix_stb,
  output logic               o_hs,
  output logic               o_vs,
  output logic               o_blanking,
  output logic               o_active,
  output logic               o_screenend,
  output logic               o_animate,
  output logic               o_line_end,
  output logic [X_W-1:0]     o_x,
  output logic [Y_W-1:0]     o_y,
  output logic [FRAME_W-1:0] o_frame
);

  localparam int H_TOTAL = H_FP + H_SYNC + H_BP + H_ACTIVE;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HA_STA  = H_FP + H_SYNC + H_BP;

  // Catch parameter sets that cannot be represented or make no sense.
  if (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_bad_cnt_w
    $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed 2^CNT_W");
  end
  if (H_ACTIVE > (1 << X_W) || V_ACTIVE > (1 << Y_W)) begin : g_bad_xy_w
    $error("vga_timing_gen: active size exceeds o_x/o_y width");
  end
  if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_zero
    $error("vga_timing_gen: porch, sync and active parameters must be non-zero");
  end

  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] HS_STA     = CNT_W'(H_FP);
  localparam logic [CNT_W-1:0] HS_END     = CNT_W'(H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] HA_STA_C   = CNT_W'(HA_STA);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_ACT_END  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_LAST = CNT_W'(V_ACTIVE - 1);
  localparam logic [CNT_W-1:0] VS_STA     = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END     = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [Y_W-1:0]   Y_CLAMP    = Y_W'(V_ACTIVE - 1);

  logic [CNT_W-1:0]   h_q, h_d;
  logic [CNT_W-1:0]   v_q, v_d;
  logic [FRAME_W-1:0] frame_q, frame_d;

  logic h_last, v_last, h_act, v_act;

  assign h_last = (h_q == H_LAST);
  assign v_last = (v_q == V_LAST);
  assign h_act  = (h_q >= HA_STA_C);
  assign v_act  = (v_q <  V_ACT_END);

  // Line end and frame end can land on the same strobe. In that case h, v and
  // the frame count all update together on one edge.
  always_comb begin
    h_d     = h_q;
    v_d     = v_q;
    frame_d = frame_q;
    if (i_pix_stb) begin
      if (h_last) begin
        h_d = '0;
        if (v_last) begin
          v_d     = '0;
          frame_d = frame_q + 1'b1;
        end else begin
          v_d = v_q + 1'b1;
        end
      end else begin
        h_d = h_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      h_q     <= '0;
      v_q     <= '0;
      frame_q <= '0;
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      frame_q <= frame_d;
    end
  end

  assign o_hs = ((h_q >= HS_STA) && (h_q < HS_END)) ? H_POL : ~H_POL;
  assign o_vs = ((v_q >= VS_STA) && (v_q < VS_END)) ? V_POL : ~V_POL;

  assign o_active   = h_act & v_act;
  assign o_blanking = ~o_active;

  assign o_x = h_act ? X_W'(h_q - HA_STA_C) : '0;
  assign o_y = v_act ? Y_W'(v_q) : Y_CLAMP;

  // Pulses are gated by the strobe. This keeps them to one clock even when
  // the counters hold on the same value for several clocks.
  assign o_line_end  = i_pix_stb & h_last;
  assign o_animate   = i_pix_stb & h_last & (v_q == V_ACT_LAST);
  assign o_screenend = i_pix_stb & h_last & v_last;

  assign o_frame = frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- d0: default 640x480 ----------------
  logic rst0 = 1'b1, stb0 = 1'b0;
  logic hs0, vs0, blk0, act0, se0, an0, le0;
  logic [9:0] x0;
  logic [8:0] y0;
  logic [15:0] fr0;

  vga_timing_gen d0 (
    .i_clk(clk), .i_rst(rst0), .i_pix_stb(stb0),
    .o_hs(hs0), .o_vs(vs0), .o_blanking(blk0), .o_active(act0),
    .o_screenend(se0), .o_animate(an0), .o_line_end(le0),
    .o_x(x0), .o_y(y0), .o_frame(fr0)
  );

  // ---------------- d1: 800x600, positive syncs ----------------
  logic rst1 = 1'b1, stb1 = 1'b0;
  logic hs1, vs1, blk1, act1, se1, an1, le1;
  logic [9:0] x1;
  logic [9:0] y1;
  logic [15:0] fr1;

  vga_timing_gen #(
    .H_ACTIVE(800), .H_FP(40), .H_SYNC(128), .H_BP(88),
    .V_ACTIVE(600), .V_FP(1), .V_SYNC(4), .V_BP(23),
    .H_POL(1'b1), .V_POL(1'b1), .X_W(10), .Y_W(10), .CNT_W(11), .FRAME_W(16)
  ) d1 (
    .i_clk(clk), .i_rst(rst1), .i_pix_stb(stb1),
    .o_hs(hs1), .o_vs(vs1), .o_blanking(blk1), .o_active(act1),
    .o_screenend(se1), .o_animate(an1), .o_line_end(le1),
    .o_x(x1), .o_y(y1), .o_frame(fr1)
  );

  // ---------------- d2: tiny 4x3 raster, 2-bit frame ----------------
  // h: 0 FP, 1 sync, 2 BP, 3..6 active (H_TOTAL=7)
  // v: 0..2 active, 3 FP, 4..5 sync, 6 BP (V_TOTAL=7)
  logic rst2 = 1'b1, stb2 = 1'b0;
  logic hs2, vs2, blk2, act2, se2, an2, le2;
  logic [2:0] x2;
  logic [1:0] y2;
  logic [1:0] fr2;

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_POL(1'b0), .V_POL(1'b0), .X_W(3), .Y_W(2), .CNT_W(3), .FRAME_W(2)
  ) d2 (
    .i_clk(clk), .i_rst(rst2), .i_pix_stb(stb2),
    .o_hs(hs2), .o_vs(vs2), .o_blanking(blk2), .o_active(act2),
    .o_screenend(se2), .o_animate(an2), .o_line_end(le2),
    .o_x(x2), .o_y(y2), .o_frame(fr2)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int s;

    // ===== d0 =====
    step(1);
    rst0 = 1'b0;
    check("d0_rst_hs", hs0, 1);
    check("d0_rst_vs", vs0, 1);
    check("d0_rst_blank", blk0, 1);
    check("d0_rst_active", act0, 0);
    check("d0_rst_x", x0, 0);
    check("d0_rst_y", y0, 0);
    check("d0_rst_se", se0, 0);
    check("d0_rst_an", an0, 0);
    check("d0_rst_le", le0, 0);
    check("d0_rst_frame", fr0, 0);
    stb0 = 1'b1;
    step(15);  check("d0_hs_h15", hs0, 1);
    step(1);   check("d0_hs_h16", hs0, 0);
    step(95);  check("d0_hs_h111", hs0, 0);
    step(1);   check("d0_hs_h112", hs0, 1);
    step(47);  check("d0_act_h159", act0, 0);
    step(1);   check("d0_act_h160", act0, 1);
               check("d0_x_h160", x0, 0);
               check("d0_blank_h160", blk0, 0);
    step(639); check("d0_le_h799", le0, 1);
               check("d0_x_h799", x0, 639);
               check("d0_an_v0", an0, 0);
    step(1);   check("d0_le_h0v1", le0, 0);
               check("d0_y_v1", y0, 1);
               check("d0_act_h0v1", act0, 0);
    step(400); check("d0_x_h400", x0, 240);
    rst0 = 1'b1;
    step(1);
    rst0 = 1'b0; stb0 = 1'b0;
    check("d0_mrst_x", x0, 0);
    check("d0_mrst_y", y0, 0);
    check("d0_mrst_hs", hs0, 1);
    check("d0_mrst_blank", blk0, 1);
    check("d0_mrst_le", le0, 0);

    // ===== d1 =====
    rst1 = 1'b0;
    check("d1_rst_hs", hs1, 0);
    check("d1_rst_vs", vs1, 0);
    stb1 = 1'b1;
    step(39);  check("d1_hs_h39", hs1, 0);
    step(1);   check("d1_hs_h40", hs1, 1);
    step(127); check("d1_hs_h167", hs1, 1);
    step(1);   check("d1_hs_h168", hs1, 0);
    step(88);  check("d1_act_h256", act1, 1);
               check("d1_x_h256", x1, 0);
    step(799); check("d1_le_h1055", le1, 1);
               check("d1_x_h1055", x1, 799);
    step(1);   check("d1_y_v1", y1, 1);
               check("d1_le_h0", le1, 0);
    stb1 = 1'b0;

    // ===== d2 =====
    // Reset held with strobe high: the counters must not move.
    stb2 = 1'b1;
    step(2);
    rst2 = 1'b0; stb2 = 1'b0;
    check("d2_rst_hs", hs2, 1);
    check("d2_rst_x", x2, 0);
    check("d2_rst_frame", fr2, 0);
    stb2 = 1'b1;
    check("d2_le_h0", le2, 0);
    step(1);   check("d2_hs_h1", hs2, 0);
    step(19);  check("d2_an_v2h6", an2, 1);   // 20 strobes: v=2, h=6
               check("d2_le_v2h6", le2, 1);
               check("d2_se_v2h6", se2, 0);
               check("d2_x_v2h6", x2, 3);
               check("d2_y_v2h6", y2, 2);
    step(1);   check("d2_an_v3h0", an2, 0);
               check("d2_y_v3", y2, 2);
               check("d2_vs_v3", vs2, 1);
               check("d2_act_v3", act2, 0);
    step(7);   check("d2_vs_v4", vs2, 0);
               check("d2_y_v4", y2, 2);
    step(7);   check("d2_vs_v5", vs2, 0);
    step(7);   check("d2_vs_v6", vs2, 1);
    step(6);   check("d2_se_v6h6", se2, 1);
               check("d2_an_v6h6", an2, 0);
               check("d2_fr_before", fr2, 0);
    step(1);   check("d2_se_after", se2, 0);
               check("d2_fr_after", fr2, 1);
               check("d2_y_wrap", y2, 0);
               check("d2_vs_wrap", vs2, 1);
    // Sparse strobe, 1 of 4 clocks, starting at h=3 (x=0).
    step(3);   check("d2_x_h3", x2, 0);
    s = 0;
    for (int i = 0; i < 8; i++) begin
      stb2 = (i % 4 == 0);
      check("d2_sparse_le", le2, 0);
      step(1);
      if (i % 4 == 0) s++;
      check("d2_sparse_x", x2, 3'(s));
    end
    // Now h=5. Move to h=6 and check that the pulse follows the strobe.
    stb2 = 1'b1;
    step(1);
    stb2 = 1'b0; #1 check("d2_le_nostb", le2, 0);
    stb2 = 1'b1; #1 check("d2_le_stb", le2, 1);
    step(1);   check("d2_le_next", le2, 0);
               check("d2_y_v1", y2, 1);
    step(4);   check("d2_x_v1h4", x2, 1);
    // Reset in the middle of a frame, while the frame count is non-zero.
    rst2 = 1'b1;
    step(1);
    rst2 = 1'b0; stb2 = 1'b0;
    check("d2_mrst_frame", fr2, 0);
    check("d2_mrst_x", x2, 0);
    check("d2_mrst_y", y2, 0);
    check("d2_mrst_vs", vs2, 1);
    check("d2_mrst_se", se2, 0);
    // Run four full frames to take the 2-bit frame count from 3 back to 0.
    stb2 = 1'b1;
    step(195); check("d2_se_f3", se2, 1);
               check("d2_fr_3", fr2, 3);
    step(1);   check("d2_fr_wrap", fr2, 0);
               check("d2_se_wrap", se2, 0);
               check("d2_x_wrap", x2, 0);
    stb2 = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  H_ACTIVE, 640, active pixels per line
  H_FP, 16, horizontal front porch (pixels)
  H_SYNC, 96, horizontal sync width (pixels)
  H_BP, 48, horizontal back porch (pixels)
  V_ACTIVE, 480, active lines per frame
  V_FP, 10, vertical front porch (lines)
  V_SYNC, 2, vertical sync width (lines)
  V_BP, 33, vertical back porch (lines)
  H_POL, 0, hsync asserted level (0 = active-low)
  V_POL, 0, vsync asserted level (0 = active-low)
  X_W, 10, width of o_x
  Y_W, 9, width of o_y
  CNT_W, 11, width of the internal h/v counters
  FRAME_W, 16, width of o_frame
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  i_clk  in  1  sole clock; all state on rising edge
  i_rst  in  1  synchronous, active-high reset
  i_pix_stb  in  1  pixel strobe; counters advance only when high
  o_hs  out  1  horizontal sync at H_POL polarity
  o_vs  out  1  vertical sync at V_POL polarity
  o_blanking  out  1  high outside the active region
  o_active  out  1  high inside the active region; always equals ~o_blanking
  o_screenend  out  1  one-clock pulse on the last pixel of the frame
  o_animate  out  1  one-clock pulse on the last pixel of the last active line
  o_line_end  out  1  one-clock pulse on the last pixel of every line
  o_x  out  X_W  active pixel x position
  o_y  out  Y_W  active pixel y position
  o_frame  out  FRAME_W  frame count
REQ-003 The block SHALL use one clock, i_clk, and a synchronous, active-high reset, i_rst.

Function
REQ-004 Derived constants: H_TOTAL = H_FP+H_SYNC+H_BP+H_ACTIVE; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP; HA_STA = H_FP+H_SYNC+H_BP.
REQ-005 Elaboration SHALL fail if any of the following holds:
  - H_TOTAL > 2^CNT_W or V_TOTAL > 2^CNT_W
  - H_ACTIVE > 2^X_W or V_ACTIVE > 2^Y_W
  - any porch, sync or active parameter is 0
REQ-006 Horizontal line order SHALL be: front porch, then sync, then back porch, then active pixels.
REQ-007 Vertical frame order SHALL be: active lines, then front porch, then sync, then back porch.
REQ-008 Horizontal counter h: when i_pix_stb=1, h SHALL increment, and SHALL wrap from H_TOTAL-1 to 0; when i_pix_stb=0, h SHALL hold.
REQ-009 Vertical counter v: v SHALL increment only on a strobed cycle with h=H_TOTAL-1, and SHALL wrap from V_TOTAL-1 to 0 on that same cycle.
REQ-010 o_frame SHALL increment, modulo 2^FRAME_W, on a strobed cycle with h=H_TOTAL-1 and v=V_TOTAL-1.
REQ-011 hsync asserted region SHALL be H_FP <= h < H_FP+H_SYNC, where o_hs = H_POL; otherwise o_hs = ~H_POL.
REQ-012 vsync asserted region SHALL be V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC, where o_vs = V_POL; otherwise o_vs = ~V_POL.
REQ-013 o_active SHALL be 1 exactly when h >= HA_STA and v < V_ACTIVE.
REQ-014 o_x SHALL be h-HA_STA when h >= HA_STA, and 0 otherwise.
REQ-015 o_y SHALL be v when v < V_ACTIVE, and V_ACTIVE-1 otherwise.
REQ-016 Pulse outputs SHALL all be qualified by i_pix_stb, so each is high for exactly one i_clk cycle per event:
  - o_line_end: h=H_TOTAL-1
  - o_animate: h=H_TOTAL-1 and v=V_ACTIVE-1
  - o_screenend: h=H_TOTAL-1 and v=V_TOTAL-1
REQ-017 All outputs SHALL be combinational decodes of h, v, i_pix_stb and the frame register, with zero latency relative to the counters.
REQ-018 Simultaneous line end and frame end SHALL wrap h, wrap v and increment o_frame all on the same edge.

Reset
REQ-019 On an i_clk edge with i_rst=1: h, v and o_frame SHALL become 0, and i_rst SHALL override i_pix_stb.
REQ-020 Post-reset outputs SHALL be (defaults):
  - o_hs=1, o_vs=1
  - o_blanking=1, o_active=0
  - o_x=0, o_y=0
  - o_screenend=0, o_animate=0, o_line_end=0
  - o_frame=0
REQ-021 Reset asserted mid-line or mid-frame SHALL restart the frame at h=0, v=0 on the next edge, with no pulse emitted for the truncated frame.

Verification
REQ-022 Reset then i_pix_stb=1 continuously -> o_hs falls at h=16, rises at h=112; o_active first goes high at h=160, v=0 with o_x=0.
REQ-023 Strobe at h=799, v=0 -> o_line_end=1 for that one clock; next state h=0, v=1.
REQ-024 Strobe at h=799, v=479 -> o_animate=1 for one clock; then o_y holds 479 through v=480..524; o_vs is low for v=490..491 only.
REQ-025 Strobe at h=799, v=524 with o_frame=0xFFFF -> o_screenend=1 for one clock; next state h=0, v=0, o_frame=0.
REQ-026 i_pix_stb toggled 1-of-4 clocks -> counters hold on non-strobe cycles and no pulse lasts more than one clock; i_rst=1 at h=400, v=200 -> all REQ-020 values on the next edge.
REQ-027 Second parameter set (800x600: H 40/128/88, V 1/4/23, H_POL=V_POL=1) -> H_TOTAL=1056, V_TOTAL=628; o_hs is high for h=40..167.
